fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the instruction memory for the RISC-V core. Holds the program counter, issues one word-aligned read per cycle to the instruction memory (registered read, one-cycle latency), buffers returned instructions with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. A redirect from the branch/jump unit flushes all buffered and in-flight fetches and restarts at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- DEPTH, 2, fetch FIFO entries; power of two, ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request valid this cycle
- imem_addr  out  32  byte address of requested word; bits [1:0] always 0
- imem_rdata  in  32  instruction for the request issued in the previous cycle
- redirect_valid  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  target byte address; bits [1:0] ignored (forced to 0)
- if_valid  out  1  FIFO head holds a valid instruction
- if_ready  in  1  decode accepts head this cycle
- if_instr  out  32  head instruction
- if_pc  out  32  byte address of head instruction

## Operation
- State: pc (next address to request), inflight (1 bit: request issued last cycle), inflight_pc, kill (drop next response), FIFO of {pc, instr} with count 0..DEPTH.
- pop = if_valid & if_ready.
- Issue rule: imem_req = !redirect_valid & (count + inflight − pop < DEPTH). imem_addr = pc. On issue: inflight_pc ← pc, pc ← pc + 4, inflight ← 1; else inflight ← 0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Response: when inflight & !kill, push {inflight_pc, imem_rdata} into FIFO. Push and pop in same cycle allowed; count unchanged.
- Credit rule guarantees push never occurs when FIFO full; overflow is a design error (assert in bench).
- Redirect (redirect_valid = 1): pc ← {redirect_pc[31:2], 2'b00}; FIFO count ← 0; kill ← inflight (drops the response arriving next cycle); imem_req forced 0 this cycle. A pop in the same cycle still counts as a completed transfer for decode; all other entries discarded.
- kill clears the cycle after it is used; redirect on consecutive cycles: last one wins.
- if_valid = (count != 0); if_instr/if_pc are registered FIFO head contents (no combinational path from imem_rdata).
- No path from if_ready or redirect_valid to imem_addr; imem_req depends combinationally on if_ready and redirect_valid only.

## Timing
- Reset (rst_n low, asynchronous): pc = RESET_PC, inflight = 0, kill = 0, count = 0, if_valid = 0, if_instr = 0, if_pc = 0, imem_req = 0 while rst_n low.
- First cycle after release: imem_req = 1, imem_addr = RESET_PC.
- Latency: request in cycle N → instruction at FIFO head (if_valid = 1) in cycle N+2.
- Throughput: one instruction per cycle with if_ready held high, DEPTH = 2, no bubbles after initial 2-cycle fill.
- if_ready low: FIFO fills to DEPTH, then imem_req deasserts; resumes the cycle a pop occurs.
- Redirect in cycle R: first target request in cycle R+1; target instruction at head in R+3. No stale instruction ever presented after R.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial transfer completes.

## Test plan
- Reset release, RESET_PC = 0, if_ready = 1, memory word k = k: imem_addr 0,4,8,… each cycle; if_valid first high 2 cycles after release with if_pc 0, if_instr 0, then 1 instr/cycle, no gaps.
- if_ready low for 6 cycles mid-stream: count saturates at 2, imem_req low, no drops/duplicates; sequence resumes in PC order on if_ready high.
- redirect_valid with redirect_pc 32'h0000_0103 while FIFO full and request in flight: next imem_addr = 32'h100, in-flight response discarded, next accepted if_pc = 32'h100.
- Redirect coincident with pop, then second redirect next cycle to 32'h200: only 32'h200 stream appears after the popped instruction.
- RESET_PC = 32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst_n low while if_valid = 1 and request in flight: if_valid drops asynchronously, restart at RESET_PC on release.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch controller. Holds the PC, issues one
//                word-aligned read per cycle to a registered-read instruction
//                memory, buffers returned {pc, instr} pairs in a small FIFO
//                and presents them to decode over valid/ready. A redirect
//                flushes buffered and in-flight fetches and restarts at the
//                target address.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    // Fetch-side state
    logic [31:0]        r_pc;
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;
    logic               r_kill;

    // FIFO state
    logic [31:0]        r_fifo_pc    [DEPTH];
    logic [31:0]        r_fifo_instr [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_CNT_W:0]   w_used;
    logic [31:0]        w_redirect_target;

    // Handshake and credit accounting. Slots already claimed are the buffered
    // entries plus the response still in flight, minus the entry leaving now.
    // Holding off the request while rst_n is low keeps the memory idle during
    // reset even though the credit check alone would allow a request.
    assign w_pop             = (r_count != '0) & if_ready;
    assign w_used            = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight)
                             - (c_CNT_W + 1)'(w_pop);
    assign w_issue           = rst_n & ~redirect_valid & (w_used < c_DEPTH);
    assign w_push            = r_inflight & ~r_kill & ~redirect_valid;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    assign if_valid  = (r_count != '0);
    assign if_pc     = r_fifo_pc[r_rd_ptr];
    assign if_instr  = r_fifo_instr[r_rd_ptr];

    // PC, in-flight tracking and response-kill flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
            r_kill        <= 1'b0;
        end else if (redirect_valid) begin
            // The response for a request issued last cycle lands next cycle
            // and must be dropped; no request goes out this cycle.
            r_pc       <= w_redirect_target;
            r_inflight <= 1'b0;
            r_kill     <= r_inflight;
        end else begin
            r_kill     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: each entry captures the returning word and its PC
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry gi written when it is the current write slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_fifo_pc[gi]    <= 32'h0000_0000;
                    r_fifo_instr[gi] <= 32'h0000_0000;
                end else if (w_push && (r_wr_ptr == c_PTR_W'(gi))) begin
                    r_fifo_pc[gi]    <= r_inflight_pc;
                    r_fifo_instr[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. Directed cycle
//                table, hand sequences for wrap-around and mid-run reset,
//                and randomized stimulus checked against a queue-based model
//                of the fetch stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int          TB_DEPTH = 2;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;

    // Main instance (RESET_PC = 0)
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    // Wrap-around instance (RESET_PC near top of address space)
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        if_valid2;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2    = 32'h0;
    logic        if_ready2       = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(TB_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    fetch_sequencer #(.RESET_PC(WRAP_PC), .DEPTH(TB_DEPTH)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .if_valid       (if_valid2),
        .if_ready       (if_ready2),
        .if_instr       (if_instr2),
        .if_pc          (if_pc2)
    );

    // Memory contents: word k holds value k
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Registered-read memories; unrequested cycles return junk
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? word_at(imem_addr)  : $urandom();
        imem_rdata2 <= imem_req2 ? word_at(imem_addr2) : $urandom();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model sees the fetch stream as a list of requested addresses that
    // have not been delivered or flushed. An address requested in cycle N is
    // deliverable from cycle N+2; a redirect discards the whole list.
    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_addr;
    int          m_cyc;

    task automatic model_reset(input logic [31:0] start);
        q.delete();
        m_addr = start;
        m_cyc  = 0;
    endtask

    task automatic model_cycle();
        bit exp_valid;
        bit exp_pop;
        bit exp_req;
        int occ;
        exp_valid = 1'b0;
        if (q.size() > 0) begin
            if (q[0].cyc <= m_cyc - 2) exp_valid = 1'b1;
        end
        exp_pop = exp_valid && if_ready;
        occ     = q.size() - (exp_pop ? 1 : 0);
        exp_req = !redirect_valid && (occ < TB_DEPTH);
        chk("model_req",   32'(imem_req),  32'(exp_req));
        chk("model_addr",  imem_addr,      m_addr);
        chk("model_valid", 32'(if_valid),  32'(exp_valid));
        if (exp_valid) begin
            chk("model_pc",    if_pc,    q[0].addr);
            chk("model_instr", if_instr, word_at(q[0].addr));
        end
        if (exp_pop) void'(q.pop_front());
        if (redirect_valid) begin
            q.delete();
            m_addr = redirect_pc & 32'hFFFF_FFFC;
        end else if (exp_req) begin
            q.push_back('{m_addr, m_cyc});
            m_addr = m_addr + 32'd4;
        end
        m_cyc++;
    endtask

    // Drive inputs mid-cycle and let combinational outputs settle
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // Model check, then advance past the next rising edge
    task automatic finish_cycle();
        model_cycle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // cycle 0 = first cycle after reset release
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000}); // c0
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000}); // c1
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000}); // c2
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004}); // c3
        for (int i = 0; i < 6; i++)                                           // c4..c9 stall
            vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 32'h010, 1'b1, 32'h008});
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008}); // c10
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C}); // c11
        vecs.push_back('{1'b0, 1'b1, 32'h103, 1'b0, 32'h018, 1'b1, 32'h010}); // c12 redirect
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000}); // c13
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000}); // c14
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100}); // c15
        vecs.push_back('{1'b1, 1'b1, 32'h180, 1'b0, 32'h10C, 1'b1, 32'h104}); // c16 redirect+pop
        vecs.push_back('{1'b1, 1'b1, 32'h200, 1'b0, 32'h180, 1'b0, 32'h000}); // c17 redirect
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000}); // c18
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000}); // c19
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200}); // c20
        vecs.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h204}); // c21

        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #2;

        // Reset state
        chk("rst_req",    32'(imem_req),  32'd0);
        chk("rst_valid",  32'(if_valid),  32'd0);
        chk("rst_pc",     if_pc,          32'd0);
        chk("rst_instr",  if_instr,       32'd0);
        chk("rst_addr",   imem_addr,      32'd0);
        chk("rst_req2",   32'(imem_req2), 32'd0);
        chk("rst_addr2",  imem_addr2,     WRAP_PC);

        rst_n = 1'b1;
        model_reset(32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("tbl%0d_req", i),   32'(imem_req), 32'(vecs[i].req));
            chk($sformatf("tbl%0d_addr", i),  imem_addr,     vecs[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("tbl%0d_pc", i),    if_pc,    vecs[i].pc);
                chk($sformatf("tbl%0d_instr", i), if_instr, word_at(vecs[i].pc));
            end
            // Wrap-around instance runs with ready high from the same release
            if (i < 4) begin
                chk($sformatf("wrap%0d_req", i),  32'(imem_req2), 32'd1);
                chk($sformatf("wrap%0d_addr", i), imem_addr2,     WRAP_PC + 32'(4 * i));
            end
            if (i < 2) chk($sformatf("wrap%0d_valid", i), 32'(if_valid2), 32'd0);
            if (i >= 2 && i < 6) begin
                chk($sformatf("wrap%0d_valid", i), 32'(if_valid2), 32'd1);
                chk($sformatf("wrap%0d_pc", i),    if_pc2,    WRAP_PC + 32'(4 * (i - 2)));
                chk($sformatf("wrap%0d_instr", i), if_instr2, word_at(WRAP_PC + 32'(4 * (i - 2))));
            end
            finish_cycle();
        end

        // Streaming, then asynchronous reset with a valid head and a request in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            finish_cycle();
        end
        drive(1'b1, 1'b0, 32'h0);
        chk("pre_rst_valid", 32'(if_valid), 32'd1);
        chk("pre_rst_req",   32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(if_valid), 32'd0);
        chk("async_rst_req",   32'(imem_req), 32'd0);
        chk("async_rst_pc",    if_pc,         32'd0);
        chk("async_rst_instr", if_instr,      32'd0);
        chk("async_rst_addr",  imem_addr,     32'd0);
        @(posedge clk);
        #2;
        chk("held_rst_valid", 32'(if_valid), 32'd0);
        chk("held_rst_req",   32'(imem_req), 32'd0);
        rst_n = 1'b1;
        model_reset(32'h0);
        drive(1'b1, 1'b0, 32'h0);
        chk("restart_req",  32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr,     32'd0);
        finish_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            finish_cycle();
        end

        // Randomized traffic: ready stalls, isolated and back-to-back redirects
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), $urandom());
            finish_cycle();
        end

        // Drain with ready held high: the stream must resume with no redirects
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            finish_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
